// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe definitions: FSM states, winner codes, cell indices and the
// eight winning-line masks over the 9-bit board vector (bit0 = a .. bit8 = i).
package ttt_pkg;

  typedef enum logic [1:0] {
    PLAY      = 2'd0,
    CHECK     = 2'd1,
    GAME_OVER = 2'd2
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  localparam int A_IDX = 0;
  localparam int B_IDX = 1;
  localparam int C_IDX = 2;
  localparam int D_IDX = 3;
  localparam int E_IDX = 4;
  localparam int F_IDX = 5;
  localparam int G_IDX = 6;
  localparam int H_IDX = 7;
  localparam int I_IDX = 8;

  localparam logic [8:0] LINE_ABC = 9'b000_000_111;
  localparam logic [8:0] LINE_DEF = 9'b000_111_000;
  localparam logic [8:0] LINE_GHI = 9'b111_000_000;
  localparam logic [8:0] LINE_ADG = 9'b001_001_001;
  localparam logic [8:0] LINE_BEH = 9'b010_010_010;
  localparam logic [8:0] LINE_CFI = 9'b100_100_100;
  localparam logic [8:0] LINE_AEI = 9'b100_010_001;
  localparam logic [8:0] LINE_CEG = 9'b001_010_100;

  localparam logic [7:0][8:0] LINE_MASKS = {
    LINE_CEG, LINE_AEI, LINE_CFI, LINE_BEH,
    LINE_ADG, LINE_GHI, LINE_DEF, LINE_ABC
  };

endpackage

// File: rtl/ttt_line_checker.sv
// Combinational win detector: high when the given player owns all three cells of
// any of the eight lines.
module ttt_line_checker
  import ttt_pkg::*;
(
  input  logic [8:0] occupied,
  input  logic [8:0] owner,
  input  logic       player,
  output logic       win
);

  logic [8:0] mine;

  // owner only means something where the cell is occupied
  assign mine = occupied & (player ? owner : ~owner);

  always_comb begin
    win = 1'b0;
    for (int l = 0; l < 8; l++) begin
      if ((mine & LINE_MASKS[l]) == LINE_MASKS[l]) win = 1'b1;
    end
  end

endmodule

// File: rtl/ttt_board_controller.sv
// Tic-tac-toe referee: edge-detects cell presses, records legal moves, alternates
// turns and declares win/draw. All outputs come straight from registers.
module ttt_board_controller
  import ttt_pkg::*;
#(
  parameter bit P1_STARTS = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       a_button,
  input  logic       b_button,
  input  logic       c_button,
  input  logic       d_button,
  input  logic       e_button,
  input  logic       f_button,
  input  logic       g_button,
  input  logic       h_button,
  input  logic       i_button,
  input  logic       new_game,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       e,
  output logic       f,
  output logic       g,
  output logic       h,
  output logic       i,
  output logic [8:0] owner,
  output logic       p1_turn,
  output logic       illegal_move,
  output logic       game_over,
  output logic [1:0] winner,
  output state_t     state_dbg
);

  // Handshake: none. Buttons are level requests; each 0->1 transition of the
  // sampled vector is one request, consumed or rejected in the following cycle.

  logic [8:0] buttons;
  logic [8:0] btn_q;
  logic [8:0] prev_q;
  logic [8:0] rise;

  state_t     state_q,   state_nxt;
  logic [8:0] occ_q,     occ_nxt;
  logic [8:0] own_q,     own_nxt;
  logic       turn_q,    turn_nxt;
  logic       illegal_q, illegal_nxt;
  logic [1:0] winner_q,  winner_nxt;
  logic       mover_wins;

  assign buttons = {i_button, h_button, g_button, f_button, e_button,
                    d_button, c_button, b_button, a_button};

  // Buttons are registered first so no path exists from a pin to any output.
  assign rise = btn_q & ~prev_q;

  ttt_line_checker u_line_checker (
    .occupied (occ_q),
    .owner    (own_q),
    .player   (turn_q),
    .win      (mover_wins)
  );

  always_comb begin
    state_nxt   = state_q;
    occ_nxt     = occ_q;
    own_nxt     = own_q;
    turn_nxt    = turn_q;
    illegal_nxt = 1'b0;
    winner_nxt  = winner_q;
    case (state_q)
      PLAY: begin
        if (rise != 9'd0) begin
          if ($onehot(rise) && ((rise & occ_q) == 9'd0)) begin
            occ_nxt   = occ_q | rise;
            own_nxt   = turn_q ? (own_q | rise) : (own_q & ~rise);
            state_nxt = CHECK;
          end else begin
            illegal_nxt = 1'b1;
          end
        end
      end
      CHECK: begin
        if (mover_wins) begin
          winner_nxt = turn_q ? WIN_P1 : WIN_P2;
          state_nxt  = GAME_OVER;
        end else if (&occ_q) begin
          winner_nxt = WIN_DRAW;
          state_nxt  = GAME_OVER;
        end else begin
          turn_nxt  = ~turn_q;
          state_nxt = PLAY;
        end
      end
      GAME_OVER: begin
        if (new_game) begin
          occ_nxt    = 9'd0;
          own_nxt    = 9'd0;
          winner_nxt = WIN_NONE;
          turn_nxt   = P1_STARTS;
          state_nxt  = PLAY;
        end
      end
      default: state_nxt = PLAY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_q     <= 9'd0;
      prev_q    <= 9'd0;
      state_q   <= PLAY;
      occ_q     <= 9'd0;
      own_q     <= 9'd0;
      turn_q    <= P1_STARTS;
      illegal_q <= 1'b0;
      winner_q  <= WIN_NONE;
    end else begin
      btn_q     <= buttons;
      prev_q    <= btn_q;
      state_q   <= state_nxt;
      occ_q     <= occ_nxt;
      own_q     <= own_nxt;
      turn_q    <= turn_nxt;
      illegal_q <= illegal_nxt;
      winner_q  <= winner_nxt;
    end
  end

  assign a            = occ_q[A_IDX];
  assign b            = occ_q[B_IDX];
  assign c            = occ_q[C_IDX];
  assign d            = occ_q[D_IDX];
  assign e            = occ_q[E_IDX];
  assign f            = occ_q[F_IDX];
  assign g            = occ_q[G_IDX];
  assign h            = occ_q[H_IDX];
  assign i            = occ_q[I_IDX];
  assign owner        = own_q;
  assign p1_turn      = turn_q;
  assign illegal_move = illegal_q;
  assign game_over    = (state_q == GAME_OVER);
  assign winner       = winner_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_ttt_board_controller.sv
// Bench for ttt_board_controller: a cell-array game model checked against the DUT
// every cycle, plus directed scenarios with hand-computed literal expectations.
module tb_ttt_board_controller;
  import ttt_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [8:0] btn = 9'd0;
  logic       new_game = 1'b0;
  wire  [8:0] occ;
  logic [8:0] owner;
  logic       p1_turn, illegal_move, game_over;
  logic [1:0] winner;
  state_t     dbg_state;

  ttt_board_controller #(.P1_STARTS(1'b1)) dut (
    .clk(clk), .reset(reset),
    .a_button(btn[0]), .b_button(btn[1]), .c_button(btn[2]),
    .d_button(btn[3]), .e_button(btn[4]), .f_button(btn[5]),
    .g_button(btn[6]), .h_button(btn[7]), .i_button(btn[8]),
    .new_game(new_game),
    .a(occ[0]), .b(occ[1]), .c(occ[2]), .d(occ[3]), .e(occ[4]),
    .f(occ[5]), .g(occ[6]), .h(occ[7]), .i(occ[8]),
    .owner(owner), .p1_turn(p1_turn), .illegal_move(illegal_move),
    .game_over(game_over), .winner(winner), .state_dbg(dbg_state)
  );

  int checks = 0;
  int failures = 0;
  int ill_cnt = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Cells hold 0 = empty, 1 = player 1, 2 = player 2. The model waits one cycle
  // for the input sample, then one cycle to judge the move.
  int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                       '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
  int   m_cell [9];
  bit   m_turn_p1, m_ill, m_over, m_judging;
  int   m_win;
  logic [8:0] m_samp, m_prev;

  function automatic bit m_has_line(int who);
    for (int l = 0; l < 8; l++)
      if (m_cell[lines[l][0]] == who && m_cell[lines[l][1]] == who &&
          m_cell[lines[l][2]] == who) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_full();
    for (int k = 0; k < 9; k++) if (m_cell[k] == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [8:0] m_occ();
    logic [8:0] v = 9'd0;
    for (int k = 0; k < 9; k++) v[k] = (m_cell[k] != 0);
    return v;
  endfunction

  function automatic logic [8:0] m_own();
    logic [8:0] v = 9'd0;
    for (int k = 0; k < 9; k++) v[k] = (m_cell[k] == 1);
    return v;
  endfunction

  always @(posedge clk) begin : model
    logic [8:0] req;
    int cnt, pos;
    if (reset) begin
      for (int k = 0; k < 9; k++) m_cell[k] = 0;
      m_turn_p1 = 1'b1; m_ill = 1'b0; m_over = 1'b0; m_judging = 1'b0;
      m_win = 0; m_samp = 9'd0; m_prev = 9'd0;
    end else begin
      req = m_samp & ~m_prev;
      m_ill = 1'b0;
      if (m_over) begin
        if (new_game) begin
          for (int k = 0; k < 9; k++) m_cell[k] = 0;
          m_turn_p1 = 1'b1; m_over = 1'b0; m_win = 0;
        end
      end else if (m_judging) begin
        m_judging = 1'b0;
        if (m_has_line(m_turn_p1 ? 1 : 2)) begin
          m_over = 1'b1; m_win = m_turn_p1 ? 1 : 2;
        end else if (m_full()) begin
          m_over = 1'b1; m_win = 3;
        end else begin
          m_turn_p1 = !m_turn_p1;
        end
      end else if (req != 9'd0) begin
        cnt = 0; pos = 0;
        for (int k = 0; k < 9; k++) if (req[k]) begin cnt++; pos = k; end
        if (cnt == 1 && m_cell[pos] == 0) begin
          m_cell[pos] = m_turn_p1 ? 1 : 2;
          m_judging = 1'b1;
        end else begin
          m_ill = 1'b1;
        end
      end
      m_prev = m_samp;
      m_samp = btn;
    end
  end

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      check("occupied", occ, m_occ());
      check("owner", owner & occ, m_own());
      check("p1_turn", {8'd0, p1_turn}, {8'd0, m_turn_p1});
      check("illegal_move", {8'd0, illegal_move}, {8'd0, m_ill});
      check("game_over", {8'd0, game_over}, {8'd0, m_over});
      check("state_dbg", {8'd0, dbg_state == GAME_OVER}, {8'd0, m_over});
      check("winner", {7'd0, winner}, 9'(m_win));
      if (illegal_move) ill_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; btn = 9'd0; new_game = 1'b0;
    idle(2);
    reset = 1'b0;
  endtask

  task automatic press(input int k);
    @(negedge clk);
    btn[k] = 1'b1;
    idle(1);
    btn[k] = 1'b0;
    idle(3);
  endtask

  task automatic press_seq(input int seq[9], input int n);
    for (int s = 0; s < n; s++) press(seq[s]);
  endtask

  // ---------------- directed stimulus ----------------
  int ill_before;
  int win_seq[9]  = '{0, 3, 1, 4, 2, 0, 0, 0, 0};
  int draw_seq[9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};

  initial begin
    idle(2);
    cmp_en = 1'b1;
    reset = 1'b0;
    idle(5);
    check("rst_occ", occ, 9'h000);
    check("rst_owner", owner, 9'h000);
    check("rst_turn", {8'd0, p1_turn}, 9'h001);
    check("rst_winner", {7'd0, winner}, 9'h000);
    check("rst_over", {8'd0, game_over}, 9'h000);
    check("rst_ill", 9'(ill_cnt), 9'd0);

    // e held for 4 cycles
    btn[4] = 1'b1;
    idle(1);
    idle(1);
    check("e_occ_n1", occ, 9'h010);
    check("e_owner_n1", {8'd0, owner[4]}, 9'h001);
    check("e_turn_n1", {8'd0, p1_turn}, 9'h001);
    idle(1);
    check("e_turn_n2", {8'd0, p1_turn}, 9'h000);
    idle(1);
    btn[4] = 1'b0;
    idle(3);
    check("e_held_once", occ, 9'h010);
    check("e_no_ill", 9'(ill_cnt), 9'd0);

    // re-press occupied e
    ill_before = ill_cnt;
    press(4);
    check("e_again_ill", 9'(ill_cnt - ill_before), 9'd1);
    check("e_again_turn", {8'd0, p1_turn}, 9'h000);
    check("e_again_occ", occ, 9'h010);

    // a and c together
    ill_before = ill_cnt;
    @(negedge clk);
    btn = 9'b000_000_101;
    idle(1);
    btn = 9'd0;
    idle(3);
    check("ac_ill", 9'(ill_cnt - ill_before), 9'd1);
    check("ac_occ", occ, 9'h010);
    check("ac_turn", {8'd0, p1_turn}, 9'h000);

    // P1 a, P2 d, P1 b, P2 e, P1 c -> P1 wins on row abc
    do_reset();
    press_seq(win_seq, 4);
    @(negedge clk);
    btn[2] = 1'b1;
    idle(1);
    btn[2] = 1'b0;
    idle(1);
    check("win_c_occ", {8'd0, occ[2]}, 9'h001);
    check("win_not_yet", {8'd0, game_over}, 9'h000);
    idle(1);
    check("win_over", {8'd0, game_over}, 9'h001);
    check("win_winner", {7'd0, winner}, 9'h001);
    check("win_turn", {8'd0, p1_turn}, 9'h001);
    check("win_owner", owner & occ, 9'b000_000_111);
    ill_before = ill_cnt;
    press(6);
    check("over_g_ign", occ, 9'b000_011_111);
    check("over_g_ill", 9'(ill_cnt - ill_before), 9'd0);
    @(negedge clk);
    new_game = 1'b1;
    idle(1);
    new_game = 1'b0;
    check("ng_occ", occ, 9'h000);
    check("ng_turn", {8'd0, p1_turn}, 9'h001);
    check("ng_winner", {7'd0, winner}, 9'h000);
    check("ng_over", {8'd0, game_over}, 9'h000);

    // new_game while playing is ignored
    press(0);
    @(negedge clk);
    new_game = 1'b1;
    idle(1);
    new_game = 1'b0;
    idle(1);
    check("ng_play_ign", occ, 9'h001);

    // draw: P1 at a,c,d,h,i; P2 at b,e,f,g
    do_reset();
    press_seq(draw_seq, 9);
    check("draw_winner", {7'd0, winner}, 9'h003);
    check("draw_over", {8'd0, game_over}, 9'h001);
    check("draw_occ", occ, 9'h1FF);
    check("draw_owner", owner, 9'b110_001_101);

    // reset arriving while the move is being judged
    do_reset();
    @(negedge clk);
    btn[0] = 1'b1;
    idle(1);
    btn[0] = 1'b0;
    idle(1);
    check("mid_occ_pre", occ, 9'h001);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    check("mid_occ", occ, 9'h000);
    check("mid_owner", owner, 9'h000);
    check("mid_turn", {8'd0, p1_turn}, 9'h001);
    check("mid_winner", {7'd0, winner}, 9'h000);
    check("mid_over", {8'd0, game_over}, 9'h000);
    idle(4);
    check("mid_stays", occ, 9'h000);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

endmodule
